// File: rtl/disp_scan_sched_if.sv
// Valid/ready link carrying {SEG,SEL} words from the scan scheduler to the HC595 serializer.
interface disp_scan_sched_if;
   logic [15:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );
endinterface

// File: rtl/disp_scan_sched.sv
// Scan scheduler for the 8-digit 7-segment display: double-buffered value, fixed-rate
// digit scan, one {SEG,SEL} word per digit handed to the serializer over valid/ready.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   WAIT  | idle until the next scan tick
//   LOAD  | build the word for the current digit from the active buffer
//   SEND  | word presented with tx_valid=1, held until tx_ready
module disp_scan_sched #(
   parameter int SCAN_DIV = 50000,
   parameter int CNT_W    = 16
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic [31:0]          Disp_Data,
   input  logic [7:0]           Dp_Mask,
   input  logic                 Zero_Blank,
   input  logic                 Upd,
   disp_scan_sched_if.master    tx,
   output logic                 frame_done,
   output logic                 overrun
);

   localparam logic [1:0] ST_WAIT = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_SEND = 2'd2;

   localparam logic [CNT_W-1:0] TICK_CNT = CNT_W'(SCAN_DIV - 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             tick;
   logic [2:0]       idx;

   logic [31:0]      sh_data;
   logic [7:0]       sh_dp;
   logic             sh_zb;
   logic             pending;

   logic [31:0]      act_data;
   logic [7:0]       act_dp;
   logic             act_zb;

   logic [7:0]       blank;
   logic             nz_above;
   logic [3:0]       nib;
   logic [7:0]       seg;
   logic [7:0]       sel;

   function automatic logic [7:0] seg_decode(input logic [3:0] n);
      logic [7:0] s;
      case (n)
         4'h0: s = 8'hC0;
         4'h1: s = 8'hF9;
         4'h2: s = 8'hA4;
         4'h3: s = 8'hB0;
         4'h4: s = 8'h99;
         4'h5: s = 8'h92;
         4'h6: s = 8'h82;
         4'h7: s = 8'hF8;
         4'h8: s = 8'h80;
         4'h9: s = 8'h90;
         4'hA: s = 8'h88;
         4'hB: s = 8'h83;
         4'hC: s = 8'hC6;
         4'hD: s = 8'hA1;
         4'hE: s = 8'h86;
         default: s = 8'h8E;
      endcase
      return s;
   endfunction

   assign tick = (cnt == TICK_CNT);

   // A digit is a leading zero when it and every digit to its left are zero; digit 0 always shows.
   always_comb begin
      nz_above = 1'b0;
      blank    = '0;
      for (int i = 7; i >= 1; i--) begin
         nz_above = nz_above | (act_data[4*i +: 4] != 4'h0);
         blank[i] = act_zb & ~nz_above;
      end
   end

   always_comb begin
      nib = act_data[{idx, 2'b00} +: 4];
      seg = blank[idx] ? 8'hFF : seg_decode(nib);
      if (act_dp[idx]) begin
         seg[7] = 1'b0;
      end
      sel = ~(8'h01 << idx);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= ST_WAIT;
         cnt         <= '0;
         idx         <= 3'd0;
         tx.tx_data  <= 16'hFFFF;
         tx.tx_valid <= 1'b0;
         frame_done  <= 1'b0;
         overrun     <= 1'b0;
         sh_data     <= 32'h0;
         sh_dp       <= 8'h0;
         sh_zb       <= 1'b0;
         pending     <= 1'b0;
         act_data    <= 32'h0;
         act_dp      <= 8'h0;
         act_zb      <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         cnt        <= tick ? '0 : cnt + 1'b1;

         // A tick while a word is in flight is lost, only flagged.
         if (tick && (state != ST_WAIT)) begin
            overrun <= 1'b1;
         end

         if (Upd) begin
            sh_data <= Disp_Data;
            sh_dp   <= Dp_Mask;
            sh_zb   <= Zero_Blank;
            pending <= 1'b1;
         end

         case (state)
            ST_WAIT: begin
               if (tick) begin
                  state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               tx.tx_data  <= {seg, sel};
               tx.tx_valid <= 1'b1;
               state       <= ST_SEND;
            end
            ST_SEND: begin
               if (tx.tx_ready) begin
                  tx.tx_valid <= 1'b0;
                  idx         <= idx + 3'd1;
                  state       <= ST_WAIT;
                  if (idx == 3'd7) begin
                     frame_done <= 1'b1;
                     // Commit uses the old shadow; a coincident Upd stays pending for the next frame.
                     if (pending) begin
                        act_data <= sh_data;
                        act_dp   <= sh_dp;
                        act_zb   <= sh_zb;
                        if (!Upd) begin
                           pending <= 1'b0;
                        end
                     end
                  end
               end
            end
            default: begin
               state <= ST_WAIT;
            end
         endcase
      end
   end

endmodule
